// File: rtl/rgb_block_writer.sv
// -----------------------------------------------------------------------------
// rgb_block_writer
//
// Takes a stream of RGB pixels that arrive in 8x8-block raster order. Inside a
// block the order is px 0..7, then py 0..7. Blocks go left to right, and each
// new block row starts 8 lines further down. Every pixel is written as one
// 32-bit word {8'h00, r, g, b} to its raster position in a linear frame buffer
// through an Avalon-MM write master.
//
// Ports
//   clk             : the single clock; all logic uses its rising edge
//   reset_n         : asynchronous reset, active low
//   start           : one-cycle pulse that begins a frame job (accepted only in IDLE)
//   base_addr       : byte address of pixel (0,0); sampled on start
//   img_width       : image width in pixels, a multiple of 8; sampled on start
//   blk_count       : number of 8x8 blocks in the job; sampled on start
//   in_valid/in_ready, in_r/in_g/in_b : pixel stream handshake and data
//   avm_address, avm_write, avm_writedata, avm_byteenable, avm_waitrequest :
//                     Avalon-MM write master
//   busy            : high while a job is active (RUN and FIN)
//   done            : one-cycle completion pulse (FIN)
// -----------------------------------------------------------------------------
module rgb_block_writer #(
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [15:0]       img_width,
   input  logic [15:0]       blk_count,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [7:0]        in_r,
   input  logic [7:0]        in_g,
   input  logic [7:0]        in_b,
   output logic [ADDR_W-1:0] avm_address,
   output logic              avm_write,
   output logic [31:0]       avm_writedata,
   output logic [3:0]        avm_byteenable,
   input  logic              avm_waitrequest,
   output logic              busy,
   output logic              done
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_FIN  = 2'd2
   } state_t;

   state_t            r_state;
   state_t            w_state_next;

   // Job parameters and position counters
   logic [15:0]       r_width;
   logic [21:0]       r_remaining;   // pixels not yet accepted
   logic              r_last_acc;    // final pixel has been accepted
   logic [2:0]        r_px;
   logic [2:0]        r_py;
   logic [12:0]       r_bcol;

   // Incremental address bases (no multiplier):
   //   r_row_base  : address of line 0, column 0 of the current block row
   //   r_blk_base  : address of (px=0, py=0) of the current block
   //   r_line_base : address of (px=0, py) of the current block
   logic [ADDR_W-1:0] r_row_base;
   logic [ADDR_W-1:0] r_blk_base;
   logic [ADDR_W-1:0] r_line_base;

   // Write-port registers
   logic [ADDR_W-1:0] r_address;
   logic              r_write;
   logic [31:0]       r_writedata;
   logic [3:0]        r_byteenable;

   logic              w_job_ok;
   logic              w_accept;
   logic              w_wr_done;
   logic              w_row_end;
   logic [ADDR_W-1:0] w_width4;      // byte stride of one image line
   logic [ADDR_W-1:0] w_width32;     // byte stride of one block row (8 lines)
   logic [ADDR_W-1:0] w_px_off;
   logic [ADDR_W-1:0] w_pix_addr;
   logic [ADDR_W-1:0] w_next_row_base;
   logic [ADDR_W-1:0] w_next_blk_base;

   assign w_job_ok  = (blk_count != 16'd0) && (img_width != 16'd0);
   assign in_ready  = (r_state == S_RUN) && (!r_write || !avm_waitrequest) && !r_last_acc;
   assign w_accept  = in_valid && in_ready;
   assign w_wr_done = r_write && !avm_waitrequest;

   // The current block is the last one in its row when it ends at img_width
   assign w_row_end = ({r_bcol, 3'b000} + 16'd8) == r_width;

   assign w_width4        = ADDR_W'(r_width) << 2;
   assign w_width32       = ADDR_W'(r_width) << 5;
   assign w_px_off        = ADDR_W'({r_px, 2'b00});
   assign w_pix_addr      = r_line_base + w_px_off;
   assign w_next_row_base = r_row_base + w_width32;
   assign w_next_blk_base = r_blk_base + ADDR_W'(32);

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_state_next = w_job_ok ? S_RUN : S_FIN;
            end
         end
         S_RUN: begin
            // Leave only once the final write has actually been taken
            if (r_last_acc && w_wr_done) begin
               w_state_next = S_FIN;
            end
         end
         S_FIN: begin
            w_state_next = S_IDLE;
         end
         default: begin
            w_state_next = S_IDLE;
         end
      endcase
   end

   assign busy = (r_state == S_RUN) || (r_state == S_FIN);
   assign done = (r_state == S_FIN);

   // ------------------------------------------------- counters and bases
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_width     <= '0;
         r_remaining <= '0;
         r_last_acc  <= 1'b0;
         r_px        <= '0;
         r_py        <= '0;
         r_bcol      <= '0;
         r_row_base  <= '0;
         r_blk_base  <= '0;
         r_line_base <= '0;
      end else if ((r_state == S_IDLE) && start) begin
         r_width     <= img_width;
         r_remaining <= {blk_count, 6'b000000};
         r_last_acc  <= 1'b0;
         r_px        <= '0;
         r_py        <= '0;
         r_bcol      <= '0;
         r_row_base  <= base_addr;
         r_blk_base  <= base_addr;
         r_line_base <= base_addr;
      end else if (w_accept) begin
         r_remaining <= r_remaining - 22'd1;
         if (r_remaining == 22'd1) begin
            r_last_acc <= 1'b1;
         end
         if (r_px != 3'd7) begin
            r_px <= r_px + 3'd1;
         end else begin
            r_px <= '0;
            if (r_py != 3'd7) begin
               r_py        <= r_py + 3'd1;
               r_line_base <= r_line_base + w_width4;
            end else begin
               r_py <= '0;
               if (w_row_end) begin
                  r_bcol      <= '0;
                  r_row_base  <= w_next_row_base;
                  r_blk_base  <= w_next_row_base;
                  r_line_base <= w_next_row_base;
               end else begin
                  r_bcol      <= r_bcol + 13'd1;
                  r_blk_base  <= w_next_blk_base;
                  r_line_base <= w_next_blk_base;
               end
            end
         end
      end else if (r_state == S_FIN) begin
         r_last_acc <= 1'b0;
      end
   end

   // ------------------------------------------------------- write port
   // A new accept reloads the port even if the previous write completes in
   // the same cycle. That is what sustains one pixel per cycle.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_address    <= '0;
         r_write      <= 1'b0;
         r_writedata  <= '0;
         r_byteenable <= '0;
      end else if (w_accept) begin
         r_address    <= w_pix_addr;
         r_write      <= 1'b1;
         r_writedata  <= {8'h00, in_r, in_g, in_b};
         r_byteenable <= 4'hF;
      end else if (w_wr_done) begin
         r_write      <= 1'b0;
         r_byteenable <= 4'h0;
      end
   end

   assign avm_address    = r_address;
   assign avm_write      = r_write;
   assign avm_writedata  = r_writedata;
   assign avm_byteenable = r_byteenable;

endmodule

// File: doc/rgb_block_writer.md
RGB_BLOCK_WRITER -- requirements
Module: rgb_block_writer

Interface
REQ-001 The block SHALL have one parameter: ADDR_W, default 32, the Avalon-MM byte address width.
REQ-002 The block SHALL have the port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-003 The block SHALL have the port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have the port start, input, 1 bit: a one-cycle pulse that begins a frame job.
REQ-005 The block SHALL have the port base_addr, input, ADDR_W bits: frame buffer byte address of pixel (0,0); sampled on start.
REQ-006 The block SHALL have the port img_width, input, 16 bits: image width in pixels, a multiple of 8; sampled on start.
REQ-007 The block SHALL have the port blk_count, input, 16 bits: the number of 8x8 blocks in the job; sampled on start.
REQ-008 The block SHALL have the ports in_valid (input, 1), in_ready (output, 1), in_r (input, 8), in_g (input, 8) and in_b (input, 8): the pixel stream from the colour converters.
REQ-009 The block SHALL have the Avalon-MM master ports avm_address (output, ADDR_W), avm_write (output, 1), avm_writedata (output, 32), avm_byteenable (output, 4) and avm_waitrequest (input, 1).
REQ-010 The block SHALL have the ports busy (output, 1), high while a job is active, and done (output, 1), a one-cycle completion pulse.

Function
REQ-011 Pixel input order SHALL be raster within each 8x8 block (px 0..7, then py 0..7), with blocks left to right, then the next block row 8 lines down.
REQ-012 The FSM SHALL have three states, IDLE, RUN and FIN, with these transitions:
- IDLE -> RUN on start when blk_count != 0 and img_width != 0;
- IDLE -> FIN on start otherwise;
- RUN -> FIN when the write of the last pixel is accepted;
- FIN -> IDLE after one cycle.
REQ-013 done SHALL be 1 only in FIN; busy SHALL be 1 in RUN and FIN.
REQ-014 start SHALL be ignored while not in IDLE.
REQ-015 in_ready SHALL equal (state == RUN) && (!avm_write || !avm_waitrequest) && !last_accepted.
REQ-016 A pixel SHALL be accepted on in_valid && in_ready.
REQ-017 On accept, the next cycle SHALL present avm_write=1, avm_writedata={8'h00, in_r, in_g, in_b}, avm_byteenable=4'hF, and avm_address = base_addr + 4*((brow*8 + py)*img_width + bcol*8 + px).
REQ-018 The address SHALL be computed incrementally: line-base and row-base registers, no multiplier.
REQ-019 avm_address, avm_writedata and avm_write SHALL hold stable while avm_waitrequest=1.
REQ-020 avm_write SHALL drop the cycle after the write is accepted unless a new pixel is accepted in the same cycle; back-to-back writes SHALL sustain 1 pixel/cycle when waitrequest=0.
REQ-021 Counter wrap rules:
- px wraps 7 -> 0 and increments py;
- py wraps 7 -> 0 and increments bcol;
- when bcol*8 + 8 == img_width, bcol -> 0 and brow increments;
- address arithmetic is modulo 2^ADDR_W.
REQ-022 A remaining-pixel counter SHALL load blk_count*64 (22 bits) on start and decrement per accept; the final pixel is accepted when the counter reaches 1.
REQ-023 RUN SHALL exit only after the final write completes (avm_write=1 && avm_waitrequest=0).
REQ-024 in_valid while in IDLE or FIN SHALL be ignored, with in_ready=0.

Reset
REQ-025 On reset_n=0, all outputs SHALL go to 0 immediately: in_ready, avm_write, avm_address, avm_writedata, avm_byteenable, busy and done.
REQ-026 On reset_n=0, the FSM SHALL go to IDLE and all counters to 0.
REQ-027 Reset asserted mid-job SHALL abort the job: the pending write is dropped and no done pulse is issued.
REQ-028 Operation SHALL resume with the first clk edge after reset_n rises, waiting for start.

Verification
REQ-029 The bench SHALL cover single block: base=0x1000_0000, width=8, blk_count=1, 64 pixels, waitrequest=0 -> writes to 0x1000_0000..0x1000_00FC in order, pixel (r=0x12, g=0x34, b=0x56) gives data 0x00123456, byteenable=4'hF, done pulse one cycle after the 64th write.
REQ-030 The bench SHALL cover block stride: width=16, blk_count=2 -> block 0 row 1 starts at base+0x40; block 1 px0,py0 at base+0x20; the final write is at base+0x1FC.
REQ-031 The bench SHALL cover block-row wrap: width=16, blk_count=3 -> the third block's first write is at base+4*(8*16) = base+0x200.
REQ-032 The bench SHALL cover backpressure: waitrequest high for 5 cycles on pixel 10 -> address and data hold for 5 cycles, in_ready=0 throughout, no pixel is lost or duplicated, and the total write count is 64.
REQ-033 The bench SHALL cover degenerate start: blk_count=0 -> no avm_write and done high exactly in the second cycle after start; start pulsed during RUN -> no effect.
REQ-034 The bench SHALL cover reset mid-job: reset_n low after 20 pixels -> avm_write=0 and busy=0 immediately; a new job with base=0x2000 then writes its first pixel at 0x2000.
